// File: rtl/fetch_unit.sv
// fetch_unit: fetches one- or two-word instructions over a request/valid memory port and issues
// them one at a time. Define FETCH_ILLEGAL_TRAP_EN to add the sticky illegal_op output.
module fetch_unit #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [15:0]       imem_rdata,
   input  logic              imem_valid,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [6:0]        opcode,
   output logic [8:0]        operands,
   output logic [15:0]       imm,
   output logic              inst_valid,
   output logic [ADDR_W-1:0] pc_out,
   output logic              halted
`ifdef FETCH_ILLEGAL_TRAP_EN
   ,output logic             illegal_op
`endif
);

   localparam logic [6:0] OpIadd = 7'b0100000;
   localparam logic [6:0] OpLdm  = 7'b0110101;
   localparam logic [6:0] OpLdd  = 7'b0100010;
   localparam logic [6:0] OpHlt  = 7'b1100001;

   typedef enum logic [2:0] {
      StFetchOp, StWaitOp, StFetchImm, StWaitImm, StIssue, StHalted
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_out_q;
   logic [6:0]        opcode_q;
   logic [8:0]        operands_q;
   logic [15:0]       imm_q;
   logic              discard_q;
   logic              take;
   logic              two_word;

   // A response is only consumed when it is not owed to a request abandoned by redirect.
   assign take     = imem_valid && !discard_q;
   assign two_word = imem_rdata[15:9] inside {OpIadd, OpLdm, OpLdd};

`ifdef FETCH_ILLEGAL_TRAP_EN
   localparam logic [6:0] OpNop = 7'b1101000;
   logic illegal_q;
   logic legal;
   assign legal = imem_rdata[15:9] inside {
      7'b0000001, 7'b0000010, 7'b0000011, 7'b0000100, 7'b0000101, 7'b0000110, OpIadd,
      OpLdd, 7'b0100011, OpLdm, 7'b0110110, 7'b1000000, OpHlt, OpNop};
   assign illegal_op = illegal_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StFetchOp;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (redirect) begin
         state_d = StFetchOp;
      end else begin
         unique case (state_q)
            StFetchOp:  state_d = StWaitOp;
            StWaitOp:   if (take) state_d = two_word ? StFetchImm : StIssue;
            StFetchImm: state_d = StWaitImm;
            StWaitImm:  if (take) state_d = StIssue;
            StIssue:    if (!stall) state_d = (opcode_q == OpHlt) ? StHalted : StFetchOp;
            StHalted:   state_d = StHalted;
            default:    state_d = StFetchOp;
         endcase
      end
   end

   always_comb begin
      imem_req   = 1'b0;
      inst_valid = 1'b0;
      halted     = 1'b0;
      unique case (state_q)
         StFetchOp, StFetchImm: imem_req = !reset && !redirect;
         StIssue:               inst_valid = 1'b1;
         StHalted:              halted = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= ADDR_W'(RESET_PC);
         pc_out_q   <= '0;
         opcode_q   <= '0;
         operands_q <= '0;
         imm_q      <= '0;
         discard_q  <= 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
         illegal_q  <= 1'b0;
`endif
      end else begin
         if (imem_valid && discard_q) begin
            discard_q <= 1'b0;
         end
         if (redirect) begin
            pc_q <= redirect_pc;
            // The request in flight is still owed unless its response is arriving right now.
            if (state_q inside {StWaitOp, StWaitImm}) begin
               discard_q <= !take;
            end
         end else begin
            unique case (state_q)
               StFetchOp: pc_out_q <= pc_q;
               StWaitOp: begin
                  if (take) begin
                     pc_q <= pc_q + ADDR_W'(1);
`ifdef FETCH_ILLEGAL_TRAP_EN
                     if (legal) begin
                        opcode_q   <= imem_rdata[15:9];
                        operands_q <= imem_rdata[8:0];
                     end else begin
                        opcode_q   <= OpNop;
                        operands_q <= '0;
                        illegal_q  <= 1'b1;
                     end
`else
                     opcode_q   <= imem_rdata[15:9];
                     operands_q <= imem_rdata[8:0];
`endif
                     if (!two_word) begin
                        imm_q <= '0;
                     end
                  end
               end
               StWaitImm: begin
                  if (take) begin
                     pc_q  <= pc_q + ADDR_W'(1);
                     imm_q <= imem_rdata;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign imem_addr = pc_q;
   assign opcode    = opcode_q;
   assign operands  = operands_q;
   assign imm       = imm_q;
   assign pc_out    = pc_out_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a program-level model,
// using an expected-instruction queue drained by an independent monitor.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata = 16'h0;
   logic        imem_valid = 1'b0;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic [6:0]  opcode;
   logic [8:0]  operands;
   logic [15:0] imm;
   logic        inst_valid;
   logic [15:0] pc_out;
   logic        halted;

   int total = 0;
   int bad   = 0;
   int n_acc = 0;

   always #5 clk = ~clk;

   fetch_unit #(.ADDR_W(16), .RESET_PC(0)) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .imem_valid (imem_valid),
      .stall      (stall),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .opcode     (opcode),
      .operands   (operands),
      .imm        (imm),
      .inst_valid (inst_valid),
      .pc_out     (pc_out),
      .halted     (halted)
   );

   typedef struct packed {
      logic [6:0]  op;
      logic [8:0]  opd;
      logic [15:0] imm;
      logic [15:0] pc;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] model_pc;
   logic [15:0] mem [0:65535];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, got, want);
      end
   endtask

   // Program-level view: an instruction is one word, plus the following word as immediate
   // for IADD/LDM/LDD; addresses wrap at 16 bits.
   function automatic exp_t model(input logic [15:0] pc, output logic [15:0] next_pc);
      exp_t        e;
      logic [15:0] w;
      logic [15:0] p1;
      w     = mem[pc];
      p1    = pc + 16'd1;
      e.op  = w[15:9];
      e.opd = w[8:0];
      e.pc  = pc;
      if (e.op == 7'b0100000 || e.op == 7'b0110101 || e.op == 7'b0100010) begin
         e.imm   = mem[p1];
         next_pc = p1 + 16'd1;
      end else begin
         e.imm   = 16'h0;
         next_pc = p1;
      end
      return e;
   endfunction

   task automatic push_next();
      exp_t        e;
      logic [15:0] np;
      e = model(model_pc, np);
      sb.push_back(e);
      model_pc = np;
   endtask

   // Memory: in-order responses, fixed latency or random 1..3 when lat_mode is 0.
   typedef struct {
      logic [15:0] a;
      int          due;
   } rq_t;
   rq_t pend[$];
   int  cyc      = 0;
   int  last_due = 0;
   int  lat_mode = 1;

   always begin
      @(posedge clk);
      #2;
      cyc++;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         imem_valid = 1'b1;
         imem_rdata = mem[pend[0].a];
         void'(pend.pop_front());
      end else begin
         imem_valid = 1'b0;
         imem_rdata = 16'($urandom);
      end
      if (imem_req) begin : issue_blk
         int l;
         int d;
         l = (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
         d = cyc + l;
         if (d <= last_due) d = last_due + 1;
         pend.push_back('{imem_addr, d});
         last_due = d;
      end
   end

   // Monitor: every issued cycle is checked against the head; acceptance pops it.
   always @(negedge clk) begin
      if (!reset && inst_valid && !redirect) begin
         if (sb.size() == 0) begin
            if (!stall) begin
               total++;
               bad++;
               $display("FAIL unexpected_issue: got pc_out=%h opcode=%b want=none", pc_out, opcode);
            end
         end else begin
            chk("issue", {opcode, operands, imm, pc_out}, sb[0]);
            chk("no_overlap", imem_req, 1'b0);
            if (!stall) begin
               void'(sb.pop_front());
               n_acc++;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_redirect(input logic [15:0] t);
      redirect    = 1'b1;
      redirect_pc = t;
      sb.delete();
      model_pc    = t;
   endtask

   task automatic accept_one(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!inst_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got no inst_valid want inst_valid within 50 cycles", name);
      end else begin
         step();
         stall = 1'b0;
         step();
         stall = 1'b1;
      end
   endtask

   initial begin
      int n;
      int since;
      int target;
      int budget;
      reset       = 1'b1;
      stall       = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 16'h0;
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
      mem[16'h0000] = 16'h0203;
      mem[16'h0002] = 16'hC200;
      mem[16'h0004] = 16'h6A05;
      mem[16'h0005] = 16'h1234;
      mem[16'h0010] = 16'h0203;
      mem[16'h0020] = 16'h0203;
      mem[16'h0040] = 16'h8A11;

      // Reset state and first-instruction latency, then a 4-cycle stall.
      repeat (3) step();
      @(negedge clk);
      chk("reset_state", {imem_req, inst_valid, halted, opcode, operands, imm, pc_out}, 64'h0);
      sb.push_back('{7'b0000001, 9'h003, 16'h0000, 16'h0000});
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("c0_req", {imem_req, imem_addr, inst_valid}, {1'b1, 16'h0000, 1'b0});
      step();
      @(negedge clk);
      chk("c1_wait", {imem_req, inst_valid}, 2'b00);
      step();
      @(negedge clk);
      chk("c2_valid", inst_valid, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge clk);
         chk("stall_hold", {imem_req, inst_valid}, 2'b01);
      end
      step();
      stall = 1'b0;
      @(negedge clk);
      chk("accept_cycle", inst_valid, 1'b1);
      step();
      stall = 1'b1;
      @(negedge clk);
      chk("resume_req", {imem_req, imem_addr, inst_valid}, {1'b1, 16'h0001, 1'b0});
      chk("add_drained", sb.size(), 0);

      // Two-word LDM.
      step();
      do_redirect(16'h0004);
      sb.push_back('{7'b0110101, 9'h005, 16'h1234, 16'h0004});
      step();
      redirect = 1'b0;
      accept_one("ldm");
      @(negedge clk);
      chk("ldm_next_addr", {imem_req, imem_addr}, {1'b1, 16'h0006});
      chk("ldm_drained", sb.size(), 0);

      // HLT parks the unit until redirect.
      step();
      do_redirect(16'h0002);
      sb.push_back('{7'b1100001, 9'h000, 16'h0000, 16'h0002});
      step();
      redirect = 1'b0;
      accept_one("hlt");
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("halt_idle", {halted, imem_req, inst_valid}, 3'b100);
         step();
      end
      do_redirect(16'h0010);
      step();
      redirect = 1'b0;
      @(negedge clk);
      chk("unhalt", {halted, imem_req, imem_addr}, {1'b0, 1'b1, 16'h0010});

      // Redirect during WAIT_OP with 3-cycle memory: stale response must be dropped.
      lat_mode = 3;
      repeat (6) step();
      do_redirect(16'h0020);
      step();
      redirect = 1'b0;
      n = 0;
      @(negedge clk);
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("wait_req_seen", imem_req, 1'b1);
      step();
      do_redirect(16'h0040);
      sb.push_back('{7'b1000101, 9'h011, 16'h0000, 16'h0040});
      step();
      redirect = 1'b0;
      accept_one("discard");
      chk("discard_drained", sb.size(), 0);
      lat_mode = 1;

      // Two-word instruction at the top of memory takes its immediate from address 0.
      mem[16'hFFFF] = 16'h4000;
      mem[16'h0000] = 16'h00FF;
      repeat (6) step();
      do_redirect(16'hFFFF);
      sb.push_back('{7'b0100000, 9'h000, 16'h00FF, 16'hFFFF});
      step();
      redirect = 1'b0;
      accept_one("wrap");
      @(negedge clk);
      chk("wrap_next_addr", {imem_req, imem_addr}, {1'b1, 16'h0001});
      chk("wrap_drained", sb.size(), 0);

      // Random programs, random latency, random stall and spaced redirects.
      for (int i = 16'h0100; i < 16'h0200; i++) begin
         logic [15:0] w;
         w = 16'($urandom);
         if (w[15:9] == 7'b1100001) w[15:9] = 7'b0000000;
         mem[i] = w;
      end
      lat_mode = 0;
      repeat (6) step();
      for (int seg = 0; seg < 6; seg++) begin
         step();
         do_redirect(16'h0100 + 16'($urandom_range(0, 127)));
         since = 0;
         step();
         redirect = 1'b0;
         target = n_acc + 12;
         budget = 0;
         while (n_acc < target && budget < 600) begin
            while (sb.size() < 4) push_next();
            stall = ($urandom_range(0, 3) == 0);
            step();
            budget++;
            since++;
            if (since >= 8 && $urandom_range(0, 19) == 0) begin
               do_redirect(16'h0100 + 16'($urandom_range(0, 127)));
               since = 0;
               step();
               redirect = 1'b0;
            end
         end
         if (budget >= 600) begin
            total++;
            bad++;
            $display("FAIL random_progress: got %0d accepted want %0d", n_acc, target);
         end
      end
      stall = 1'b1;
      repeat (4) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
